// File: rtl/tdm_mux_8to1.sv
// Eight-lane round-robin merge onto one registered, channel-tagged output link.
// Optional build macro TDM_MUX_FIXED_SLOT_EN selects strict fixed-slot TDM instead of round-robin.
module tdm_mux_8to1 #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [8*W-1:0] in_data,
  input  logic [7:0]     in_valid,
  output logic [7:0]     in_ready,
  output logic [W-1:0]   out_data,
  output logic [2:0]     out_sel,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [2:0]   r_ptr;
  logic [W-1:0] r_out_data;
  logic [2:0]   r_out_sel;
  logic         r_out_valid;

  logic         w_load_en;
  logic [2:0]   w_grant;
  logic         w_gnt_ok;
  logic         w_xfer;
  logic [W-1:0] w_gnt_data;

  // First requesting lane at or after base, searching upward with wrap.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] base);
    logic [2:0] idx;
    logic       found;
    rr_pick = base;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = base + 3'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    w_load_en = !r_out_valid || out_ready;
`ifdef TDM_MUX_FIXED_SLOT_EN
    w_grant   = r_ptr;
    w_gnt_ok  = in_valid[r_ptr];
`else
    w_grant   = rr_pick(in_valid, r_ptr);
    w_gnt_ok  = |in_valid;
`endif
    // Reset masks ready so no source believes a beat was taken while the register is cleared.
    w_xfer     = w_load_en && w_gnt_ok && !rst;
    in_ready   = w_xfer ? (8'h01 << w_grant) : 8'h00;
    w_gnt_data = in_data[w_grant*W +: W];
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= 3'd0;
      r_out_data  <= '0;
      r_out_sel   <= 3'd0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_out_data  <= w_gnt_data;
        r_out_sel   <= w_grant;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
`ifdef TDM_MUX_FIXED_SLOT_EN
      if (w_load_en) r_ptr <= r_ptr + 3'd1;
`else
      if (w_xfer) r_ptr <= w_grant + 3'd1;
`endif
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_tdm_mux_8to1.sv
// Directed bench for tdm_mux_8to1 with a one-deep scoreboard and a small grant model.
module tb_tdm_mux_8to1;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [8*W-1:0] in_data;
  logic [7:0]     in_valid;
  logic [7:0]     in_ready;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;
  logic           out_valid;
  logic           out_ready;

  int total = 0;
  int bad   = 0;

  logic [2:0]   m_ptr;
  logic         m_ov;
  logic [W+2:0] q[$];

  tdm_mux_8to1 #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_ready();
    logic       load;
    logic       ok;
    logic [2:0] g;
    load = !m_ov || out_ready;
    ok   = 1'b0;
    g    = m_ptr;
`ifdef TDM_MUX_FIXED_SLOT_EN
    ok = in_valid[m_ptr];
`else
    for (int i = 7; i >= 0; i--) begin
      if (in_valid[(int'(m_ptr) + i) % 8]) begin
        g  = 3'((int'(m_ptr) + i) % 8);
        ok = 1'b1;
      end
    end
`endif
    return (rst || !load || !ok) ? 8'h00 : (8'h01 << g);
  endfunction

  // One clock: check combinational ready and held output, then advance the model.
  task automatic step();
    logic [7:0] er;
    logic       load;
    #1;
    er   = exp_ready();
    load = !m_ov || out_ready;
    chk("model_ready", {8'h0, in_ready}, {8'h0, er});
    chk("model_ovalid", {15'h0, out_valid}, {15'h0, m_ov});
    if (m_ov) begin
      if (q.size() == 0) chk("sb_empty", 16'd1, 16'd0);
      else begin
        chk("sb_sel", {13'h0, out_sel}, {13'h0, q[0][W+2:W]});
        chk("sb_data", {8'h0, out_data}, {8'h0, q[0][W-1:0]});
      end
    end
    @(posedge clk);
    if (rst) begin
      m_ptr = 3'd0;
      m_ov  = 1'b0;
      q.delete();
    end else begin
      if (m_ov && out_ready && q.size() != 0) void'(q.pop_front());
      if (er != 8'h00) begin
        for (int k = 0; k < 8; k++)
          if (er[k]) begin
            q.push_back({3'(k), in_data[k*W +: W]});
`ifndef TDM_MUX_FIXED_SLOT_EN
            m_ptr = 3'(k + 1);
`endif
          end
        m_ov = 1'b1;
      end else if (out_ready) m_ov = 1'b0;
`ifdef TDM_MUX_FIXED_SLOT_EN
      if (load) m_ptr = m_ptr + 3'd1;
`endif
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 8'hFF;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) in_data[k*W +: W] = 8'hA0 + 8'(k);
    m_ptr = 3'd0;
    m_ov  = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset values with every lane requesting
    #1;
    chk("rst_ready", {8'h0, in_ready}, 16'h0);
    chk("rst_ovalid", {15'h0, out_valid}, 16'h0);
    chk("rst_odata", {8'h0, out_data}, 16'h0);
    chk("rst_osel", {13'h0, out_sel}, 16'h0);
    step();
    #1;
    chk("rst_after_ovalid", {15'h0, out_valid}, 16'h0);
    chk("rst_after_ready", {8'h0, in_ready}, 16'h0);
    rst = 1'b0;

`ifdef TDM_MUX_FIXED_SLOT_EN
    // Fixed-slot: lone channel 4 is offered once per 8 cycles
    in_valid  = 8'h10;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      #1;
      chk("fx_ready", {8'h0, in_ready}, (i % 8 == 4) ? 16'h10 : 16'h0);
      if (i > 0) chk("fx_ovalid", {15'h0, out_valid}, (i % 8 == 5) ? 16'h1 : 16'h0);
      if (i % 8 == 5) chk("fx_osel", {13'h0, out_sel}, 16'h4);
      step();
    end
`else
    // Full-load rotation
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i < 9) chk("rot_ready", {8'h0, in_ready}, 16'(8'h01 << (i % 8)));
      if (i > 0) begin
        chk("rot_ovalid", {15'h0, out_valid}, 16'h1);
        chk("rot_osel", {13'h0, out_sel}, 16'((i - 1) % 8));
        chk("rot_odata", {8'h0, out_data}, 16'(8'hA0 + 8'((i - 1) % 8)));
      end
      if (i == 9) in_valid = 8'h00;
      step();
    end

    // Sparse round-robin over channels 2 and 5 from ptr=0
    do_reset();
    in_valid = 8'h24;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("sparse_ready", {8'h0, in_ready}, (i % 2 == 0) ? 16'h04 : 16'h20);
      step();
    end
    #1;
    chk("sparse_last_sel", {13'h0, out_sel}, 16'h5);

    // Stall and resume: hold a channel 3 beat, then release it
    in_valid = 8'h08;
    step();
    in_valid  = 8'h30;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_ready", {8'h0, in_ready}, 16'h0);
      chk("stall_osel", {13'h0, out_sel}, 16'h3);
      chk("stall_odata", {8'h0, out_data}, 16'hA3);
      chk("stall_ovalid", {15'h0, out_valid}, 16'h1);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("resume_ready", {8'h0, in_ready}, 16'h10);
    step();
    #1;
    chk("resume_osel", {13'h0, out_sel}, 16'h4);
    chk("resume_ovalid", {15'h0, out_valid}, 16'h1);

    // Reset mid-stream while a channel 6 beat is held
    in_valid = 8'h40;
    step();
    in_valid  = 8'h00;
    out_ready = 1'b0;
    #1;
    chk("mid_osel", {13'h0, out_sel}, 16'h6);
    step();
    rst = 1'b1;
    step();
    rst       = 1'b0;
    in_valid  = 8'h0A;
    out_ready = 1'b1;
    #1;
    chk("mid_ovalid", {15'h0, out_valid}, 16'h0);
    chk("mid_first_grant", {8'h0, in_ready}, 16'h02);
    step();
    #1;
    chk("mid_after_osel", {13'h0, out_sel}, 16'h1);
    in_valid = 8'h00;
    step();
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tdm_mux_8to1.md
# tdm_mux_8to1

Eight-channel round-robin multiplexer that merges eight independent valid/ready input streams into one tagged output stream. It is the collecting end of the 1-to-8 demultiplexer fabric: the demux fans one source out to eight lanes, and this block gathers eight lanes back onto one link. Each output beat carries the originating channel number on `out_sel`. The output is registered, so one beat is buffered, and the block sustains one beat per clock.

## Interface
- `W`, default 8: data width per channel, in bits.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  8*W  channel k data is at `[k*W +: W]`.
- `in_valid`  in  8  per-channel valid.
- `in_ready`  out  8  per-channel ready; combinational and one-hot-or-zero.
- `out_data`  out  W  registered data of the held beat.
- `out_sel`  out  3  registered channel number of the held beat.
- `out_valid`  out  1  registered; asserted while a beat is held.
- `out_ready`  in  1  downstream accept.

## Operation
- **State:**
  - Output register: `out_data`, `out_sel`, `out_valid`.
  - Pointer `ptr[2:0]`.
- **Load enable:** `load_en = !out_valid || out_ready`.
- **Grant (round-robin, default build):**
  - `grant` is the first k in order ptr, ptr+1, …, ptr+7 (mod 8) with `in_valid[k]=1`.
  - `gnt_ok` = any bit of `in_valid` is set.
- **Ready:** `in_ready[k] = load_en && gnt_ok && (grant==k)`. At most one bit is set.
- **Transfer on channel k:** occurs when `in_valid[k] && in_ready[k]`. On that edge:
  - `out_data <= in_data[k]`, `out_sel <= k`, `out_valid <= 1`.
  - `ptr <= k+1`, wrapping 7→0.
- **Output transfer:** `out_valid && out_ready`.
  - If no input transfers in the same cycle, `out_valid <= 0`.
  - If an input transfers in the same cycle, the register reloads. This is back-to-back operation with no bubble.
- **Stall:** while `out_valid=1 && out_ready=0`:
  - `in_ready` is all zero.
  - The held beat stays stable.
  - `ptr` holds.
- **Idle:** while no `in_valid` bit is set, `ptr` and the output register hold; `out_valid` clears after the final output transfer.
- **Fairness:** a channel that stays valid is served within 8 grants. No channel is served twice while another valid channel is waiting.
- **Reset:** `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`, so `in_ready=0`.
  - Reset mid-operation discards the held beat; `out_valid` is 0 on the cycle after reset.
  - `rst` has priority over all other events.
- **Input protocol:** sources must hold `in_data` and `in_valid` until the handshake completes. The block does not check this.

## Timing
- **Latency:** one cycle from the input handshake edge to `out_valid=1` carrying that beat.
- **Throughput:** one beat per clock when `out_ready=1` continuously.
- **Combinational path:** `in_ready` depends on `in_valid`, `ptr`, `out_valid` and `out_ready`.
- **Registered outputs:** `out_*` are registered only; no output has a combinational path to any input.
- **Pointer update:** `ptr` changes only on an input transfer (round-robin build) or on a slot advance (fixed-slot build).

## Configuration
- **Macro:** `TDM_MUX_FIXED_SLOT_EN`.
- **Undefined (default build):** work-conserving round-robin as described in Operation. Empty channels are skipped.
- **Defined (fixed-slot TDM):**
  - `grant = ptr`; `gnt_ok = in_valid[ptr]`.
  - `ptr` increments by 1 (wrapping 7→0) on every cycle where `load_en=1`, whether or not a transfer occurs.
  - An empty slot produces no output beat.
  - While stalled (`load_en=0`), `ptr` holds.
  - Result: channel k is offered only in its own slot, so an isolated request waits up to 7 cycles.

## Test plan
- **Reset values:** assert `rst` for 2 cycles with all `in_valid=8'hFF` → during reset and the cycle after, `in_ready=0` and `out_valid=0`; `out_data=0`; `out_sel=0`.
- **Full-load rotation:** `in_valid=8'hFF`, `out_ready=1` continuously, channel k drives data `8'hA0+k` → output sequence on `out_sel` is 0,1,…,7,0; `out_data` is A0…A7; `out_valid` is 1 on every cycle after the first.
- **Sparse round-robin:** only channels 2 and 5 valid, `ptr=0` → grants are 2,5,2,5; `ptr` goes 3,6,3,6.
- **Stall and resume:**
  - After a beat from channel 3 is held, drop `out_ready` for 4 cycles → `in_ready=0` and `out_data`/`out_sel` stay stable.
  - Raise `out_ready` → the held beat leaves and the next grant loads on the same edge.
- **Reset mid-stream:** apply reset while `out_valid=1`, `out_sel=6` → `out_valid=0` on the next cycle, `ptr=0`, and the first grant after reset goes to the lowest valid channel.
- **Fixed-slot mode:** build with `TDM_MUX_FIXED_SLOT_EN`, only channel 4 valid, `out_ready=1` → `in_ready[4]` pulses once every 8 cycles; `out_valid` is high 1 cycle in 8, with `out_sel=4`.
